// File: rtl/bp_sacc_io_arbiter.sv
// Round-robin sharing of one accelerator I/O command/response path among sacc engines.
// Optional sticky protocol-error flag is built when BP_SACC_IO_ARB_ERR_EN is defined.
module bp_sacc_io_arbiter #(
    parameter int num_req_p         = 4,
    parameter int msg_width_p       = 128,
    parameter int max_outstanding_p = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
    input  logic [num_req_p-1:0]             req_v_i,
    output logic [num_req_p-1:0]             req_yumi_o,
    output logic [msg_width_p-1:0]           cmd_o,
    output logic                             cmd_v_o,
    input  logic                             cmd_yumi_i,
    input  logic [msg_width_p-1:0]           resp_i,
    input  logic                             resp_v_i,
    output logic                             resp_yumi_o,
    output logic [msg_width_p-1:0]           req_resp_o,
    output logic [num_req_p-1:0]             req_resp_v_o,
    input  logic [num_req_p-1:0]             req_resp_yumi_i,
    output logic                             err_o
);
    localparam int IdW  = $clog2(num_req_p);
    localparam int PtrW = $clog2(max_outstanding_p);
    localparam int CntW = $clog2(max_outstanding_p + 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [IdW-1:0]   rr_q, rr_d;
    logic [IdW-1:0]   owner_q, owner_d;
    logic [IdW-1:0]   tag_mem_q [max_outstanding_p];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;

    logic             scan_found;
    logic [IdW-1:0]   scan_id;
    logic [IdW-1:0]   sel_id;
    logic [IdW-1:0]   head_id;
    logic             full, nonempty;
    logic             cmd_v, issue, pop;
    logic [msg_width_p-1:0] sel_cmd;

    // First valid engine at or after the rr pointer, wrapping.
    always_comb begin
        int idx;
        scan_found = 1'b0;
        scan_id    = '0;
        idx        = 0;
        for (int i = 0; i < num_req_p; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= num_req_p) idx = idx - num_req_p;
            if (!scan_found && req_v_i[idx[IdW-1:0]]) begin
                scan_found = 1'b1;
                scan_id    = idx[IdW-1:0];
            end
        end
    end

    assign full     = (count_q == CntW'(max_outstanding_p));
    assign nonempty = (count_q != '0);
    assign head_id  = tag_mem_q[rd_ptr_q];
    assign sel_id   = (state_q == ST_LOCKED) ? owner_q : scan_id;
    // A held grant was made while not full and count cannot rise while locked.
    assign cmd_v    = (state_q == ST_LOCKED) ? req_v_i[owner_q] : (scan_found && !full);
    assign issue    = cmd_v && cmd_yumi_i;
    assign pop      = resp_v_i && nonempty && req_resp_yumi_i[head_id];

    always_comb begin
        sel_cmd = '0;
        for (int k = 0; k < num_req_p; k++) begin
            if (sel_id == IdW'(k)) sel_cmd = req_cmd_i[k*msg_width_p +: msg_width_p];
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        count_d = count_q;
        if (issue) begin
            state_d = ST_IDLE;
            rr_d    = (sel_id == IdW'(num_req_p - 1)) ? '0 : sel_id + 1'b1;
        end else if (cmd_v) begin
            state_d = ST_LOCKED;
            owner_d = sel_id;
        end
        if (issue && !pop)      count_d = count_q + CntW'(1);
        else if (!issue && pop) count_d = count_q - CntW'(1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_q     <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < max_outstanding_p; i++) tag_mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            count_q <= count_d;
            if (issue) begin
                tag_mem_q[wr_ptr_q] <= sel_id;
                wr_ptr_q            <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Every output is forced low while reset is asserted, even mid-transaction.
    assign cmd_v_o     = reset_n_i && cmd_v;
    assign cmd_o       = cmd_v_o ? sel_cmd : '0;
    assign resp_yumi_o = reset_n_i && pop;
    assign req_resp_o  = reset_n_i ? resp_i : '0;

    always_comb begin
        for (int k = 0; k < num_req_p; k++) begin
            req_yumi_o[k]   = reset_n_i && issue && (sel_id == IdW'(k));
            req_resp_v_o[k] = reset_n_i && resp_v_i && nonempty && (head_id == IdW'(k));
        end
    end

`ifdef BP_SACC_IO_ARB_ERR_EN
    logic err_q;
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_q <= 1'b0;
        end else if ((resp_v_i && !nonempty) ||
                     ((state_q == ST_LOCKED) && !req_v_i[owner_q])) begin
            err_q <= 1'b1;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_bp_sacc_io_arbiter.sv
// Randomized and directed bench for bp_sacc_io_arbiter against a queue-based reference model.
module tb_bp_sacc_io_arbiter;
    localparam int N = 4;
    localparam int W = 128;
    localparam int D = 4;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;

    logic [N*W-1:0] req_cmd = '0;
    logic [N-1:0]   req_v = '0;
    logic [N-1:0]   req_yumi_o;
    logic [W-1:0]   cmd_o;
    logic           cmd_v_o;
    logic           cmd_yumi = 1'b0;
    logic [W-1:0]   resp = '0;
    logic           resp_v = 1'b0;
    logic           resp_yumi_o;
    logic [W-1:0]   req_resp_o;
    logic [N-1:0]   req_resp_v_o;
    logic [N-1:0]   rr_yumi = '0;
    logic           err_o;

    bp_sacc_io_arbiter #(.num_req_p(N), .msg_width_p(W), .max_outstanding_p(D)) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .req_cmd_i(req_cmd), .req_v_i(req_v), .req_yumi_o(req_yumi_o),
        .cmd_o(cmd_o), .cmd_v_o(cmd_v_o), .cmd_yumi_i(cmd_yumi),
        .resp_i(resp), .resp_v_i(resp_v), .resp_yumi_o(resp_yumi_o),
        .req_resp_o(req_resp_o), .req_resp_v_o(req_resp_v_o),
        .req_resp_yumi_i(rr_yumi), .err_o(err_o)
    );

    int n_total = 0;
    int n_bad   = 0;

    // reference model: rotation pointer, lock holder and queue of issuer ids
    int m_rr;
    bit m_lock;
    int m_owner;
    int tag_q[$];
    bit m_err;
    logic [N-1:0] last_ry;

    bit           e_v;
    int           e_g;
    logic [W-1:0] e_cmd;
    logic [N-1:0] e_ry, e_rv;
    bit           e_yumi;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_msg();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic compute_exp();
        int k;
        e_g = -1;
        e_v = 1'b0;
        if (m_lock) begin
            e_g = m_owner;
            e_v = req_v[m_owner];
        end else if (tag_q.size() < D) begin
            for (int i = 0; i < N; i++) begin
                k = (m_rr + i) % N;
                if (e_g < 0 && req_v[k]) e_g = k;
            end
            e_v = (e_g >= 0);
        end
        e_cmd = e_v ? req_cmd[e_g*W +: W] : '0;
        e_ry = '0;
        if (e_v && cmd_yumi) e_ry[e_g] = 1'b1;
        e_rv = '0;
        e_yumi = 1'b0;
        if (tag_q.size() > 0 && resp_v) begin
            e_rv[tag_q[0]] = 1'b1;
            e_yumi = rr_yumi[tag_q[0]];
        end
    endtask

    // Check all outputs for the current inputs, then advance the model across one clock edge.
    task automatic cycle();
        bit err_ev;
        bit exp_err;
        #1;
        compute_exp();
`ifdef BP_SACC_IO_ARB_ERR_EN
        exp_err = m_err;
`else
        exp_err = 1'b0;
`endif
        check_eq("cmd_v", W'(cmd_v_o), W'(e_v));
        check_eq("cmd_o", cmd_o, e_cmd);
        check_eq("req_yumi", W'(req_yumi_o), W'(e_ry));
        check_eq("req_resp_v", W'(req_resp_v_o), W'(e_rv));
        check_eq("resp_yumi", W'(resp_yumi_o), W'(e_yumi));
        check_eq("req_resp", req_resp_o, resp);
        check_eq("err", W'(err_o), W'(exp_err));
        err_ev = (resp_v && tag_q.size() == 0) || (m_lock && !req_v[m_owner]);
        @(posedge clk);
        if (e_yumi) void'(tag_q.pop_front());
        if (e_v && cmd_yumi) begin
            tag_q.push_back(e_g);
            m_rr   = (e_g + 1) % N;
            m_lock = 1'b0;
        end else if (e_v) begin
            m_lock  = 1'b1;
            m_owner = e_g;
        end
        if (err_ev) m_err = 1'b1;
        last_ry = e_ry;
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_rr = 0; m_lock = 1'b0; m_owner = 0; m_err = 1'b0; last_ry = '0;
        tag_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_v = '0; cmd_yumi = 1'b0; resp_v = 1'b0; rr_yumi = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < N; k++) req_cmd[k*W +: W] = rand_msg();
        model_reset();
        @(negedge clk);
        #1;
        check_eq("rst_cmd_v", W'(cmd_v_o), '0);
        check_eq("rst_req_resp_v", W'(req_resp_v_o), '0);
        check_eq("rst_err", W'(err_o), '0);
        do_reset();

        // rotation with immediate responses
        req_v = '1; cmd_yumi = 1'b1; rr_yumi = '1;
        for (int i = 0; i < 5; i++) begin
            resp_v = (i > 0);
            resp = rand_msg();
            #1;
            check_eq("rot_grant", W'(req_yumi_o), W'(1 << (i % N)));
            if (i > 0) check_eq("rot_route", W'(req_resp_v_o), W'(1 << ((i - 1) % N)));
            cycle();
        end

        // hold on engine 2, then wrap to engine 0
        do_reset();
        req_v = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("hold_data", cmd_o, req_cmd[2*W +: W]);
            cycle();
        end
        req_v = 4'b0101;
        #1;
        check_eq("hold_owner", cmd_o, req_cmd[2*W +: W]);
        cycle();
        cmd_yumi = 1'b1;
        #1;
        check_eq("hold_issue", W'(req_yumi_o), W'(4'b0100));
        cycle();
        req_v = 4'b0001;
        #1;
        check_eq("wrap_grant", W'(req_yumi_o), W'(4'b0001));
        cycle();

        // full blocks grants; a pop frees a slot only on the next cycle
        do_reset();
        req_v = '1; cmd_yumi = 1'b1;
        repeat (4) cycle();
        #1;
        check_eq("full_block", W'(cmd_v_o), '0);
        cycle();
        resp_v = 1'b1; rr_yumi = '1;
        #1;
        check_eq("full_same_cycle", W'(cmd_v_o), '0);
        check_eq("full_pop", W'(resp_yumi_o), W'(1));
        cycle();
        resp_v = 1'b0;
        #1;
        check_eq("full_next", W'(cmd_v_o), W'(1));
        cycle();

        // simultaneous push and pop keep occupancy, then drain
        do_reset();
        req_v = '1; cmd_yumi = 1'b1;
        repeat (2) cycle();
        resp_v = 1'b1; rr_yumi = '1;
        repeat (3) cycle();
        req_v = '0; cmd_yumi = 1'b0;
        repeat (3) cycle();
        resp_v = 1'b0;

        // unsolicited response
        do_reset();
        resp_v = 1'b1; rr_yumi = '1;
        #1;
        check_eq("unsol_yumi", W'(resp_yumi_o), '0);
        check_eq("unsol_route", W'(req_resp_v_o), '0);
        repeat (2) cycle();
        resp_v = 1'b0;
        repeat (2) cycle();

        // reset while locked with three outstanding
        do_reset();
        req_v = '1; cmd_yumi = 1'b1;
        repeat (3) cycle();
        cmd_yumi = 1'b0;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_cmd_v", W'(cmd_v_o), '0);
        check_eq("midrst_cmd", cmd_o, '0);
        check_eq("midrst_req_yumi", W'(req_yumi_o), '0);
        check_eq("midrst_resp_v", W'(req_resp_v_o), '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cmd_yumi = 1'b1;
        #1;
        check_eq("post_rst_grant", W'(req_yumi_o), W'(4'b0001));
        repeat (5) cycle();

        // randomized traffic; engines hold a command until it is consumed
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (last_ry[k]) req_v[k] = 1'b0;
                if (!req_v[k] && $urandom_range(0, 2) == 0) begin
                    req_v[k] = 1'b1;
                    req_cmd[k*W +: W] = rand_msg();
                end
            end
            cmd_yumi = 1'($urandom_range(0, 1));
            resp_v   = (tag_q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            rr_yumi  = N'($urandom);
            resp     = rand_msg();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/bp_sacc_io_arbiter.md
Name: bp_sacc_io_arbiter

Overview:
- Shares one accelerator-side I/O command path and its I/O response path among num_req_p streaming-accelerator engines inside a sacc tile.
- Arbitrates engine commands round-robin onto the single outgoing command channel toward the I/O LCE link.
- Records each issued command's requester in an in-order tag FIFO.
- Steers each returning in-order response back to the engine that issued the command.

Parameters:
- num_req_p, 4, number of accelerator engines (2..8)
- msg_width_p, 128, width of one command/response message
- max_outstanding_p, 4, tag FIFO depth = max commands in flight (power of 2, >=2)

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- req_cmd_i  in  num_req_p*msg_width_p  per-engine command, engine k at slice k
- req_v_i  in  num_req_p  per-engine command valid
- req_yumi_o  out  num_req_p  per-engine command consumed
- cmd_o  out  msg_width_p  arbitrated command
- cmd_v_o  out  1  command valid
- cmd_yumi_i  in  1  downstream consumes cmd_o
- resp_i  in  msg_width_p  returning response
- resp_v_i  in  1  response valid
- resp_yumi_o  out  1  response consumed
- req_resp_o  out  msg_width_p  response broadcast to all engines (= resp_i)
- req_resp_v_o  out  num_req_p  one-hot response valid to owning engine
- req_resp_yumi_i  in  num_req_p  engine consumes response
- err_o  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset (reset_n_i=0, async, effective immediately; may assert mid-transaction):
  - rr pointer=0, lock=0, FIFO empty, count=0, err=0.
  - All outputs 0. In-flight commands/responses are discarded.
- Grant:
  - When unlocked and count<max_outstanding_p, select the first k with req_v_i[k]=1 scanning from pointer upward, wrapping mod num_req_p.
  - cmd_v_o=1, cmd_o=req_cmd_i[k].
  - count is registered: a dequeue in the same cycle does not free a slot for a grant that cycle.
- Lock:
  - If cmd_v_o=1 and cmd_yumi_i=0, latch lock=1 and owner=k.
  - While locked, the owner is held and cmd_o tracks req_cmd_i[owner]; engines must hold valid/data until yumi.
  - Lock clears on cmd_yumi_i.
- Issue (cmd_yumi_i & cmd_v_o):
  - req_yumi_o[owner]=1 in the same cycle (combinational).
  - Push owner id into the tag FIFO.
  - pointer <= (owner+1) mod num_req_p.
  - Latency req_v_i to cmd_v_o is 0 cycles when idle and not full.
- Full: count==max_outstanding_p forces cmd_v_o=0 and all req_yumi_o=0.
- Response routing:
  - head = FIFO head id.
  - If FIFO non-empty: req_resp_v_o[head]=resp_v_i, all other bits 0.
  - resp_yumi_o = resp_v_i & req_resp_yumi_i[head] & nonempty.
  - On resp_yumi_o, pop. Responses are strictly in order.
- Simultaneous push and pop in the same cycle: count unchanged, FIFO pointers both advance.
- Unsolicited response (resp_v_i=1 with FIFO empty): resp_yumi_o=0 and req_resp_v_o=0; the response stalls.
- count width: $clog2(max_outstanding_p+1). Pointers wrap modulo depth.

Optional Feature:
- Macro: BP_SACC_IO_ARB_ERR_EN.
- When defined, err_o is a sticky register set on either event, cleared only by reset:
  - Unsolicited response: resp_v_i=1 while FIFO empty.
  - Owner drop: the locked owner deasserts req_v_i before yumi.
- When not defined, err_o is tied 0 and no error logic is instantiated.

Test Plan:
- Rotation: all 4 engines valid, cmd_yumi_i=1 each cycle, responses returned immediately → grants 0,1,2,3,0; req_resp_v_o one-hot 0001,0010,0100,1000.
- Hold: engine 2 alone valid, cmd_yumi_i=0 for 3 cycles, then engine 0 raises valid → cmd_o stays engine 2's data; after yumi, next grant is 0 via wrap from pointer 3.
- Full: 4 commands issued with no responses, all engines valid → cmd_v_o=0. Pop one response → cmd_v_o=1 the following cycle, not the same cycle.
- Push/pop: count=2, issue and respond in the same cycle → count stays 2; responses route to the original issuers in order.
- Unsolicited response: resp_v_i=1 with FIFO empty → resp_yumi_o=0, req_resp_v_o=0. With BP_SACC_IO_ARB_ERR_EN, err_o=1 from the next cycle and stays set.
- Reset: assert reset_n_i=0 mid-lock with 3 outstanding → outputs 0 immediately; after release, first grant scans from engine 0 and count=0.
